// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, ALU opcodes and
// default widths.
package alu_arb_pkg;

  localparam int IN_WIDTH_DEF  = 8;
  localparam int OUT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // ALU function codes understood by the external ALU.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_NAND = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_XNOR = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_NOP  = 4'b1111;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority.
// prio1_q set means requester 1 wins a tie; it flips only on a grant.
module rr_arb2 (
  input  logic clk,
  input  logic RST,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic prio1_q;

  // Grant the sole requester, or on a tie the one not granted last.
  always_comb begin
    gnt0 = en & req0 & (~req1 | ~prio1_q);
    gnt1 = en & req1 & (~req0 |  prio1_q);
  end

  // After granting 0, favour 1 next time, and vice versa.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)               prio1_q <= 1'b0;
    else if (gnt0 | gnt1)   prio1_q <= gnt0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU. Each operation walks
// IDLE -> LOAD -> EXEC -> RESP, so a grant in cycle T yields rsp_valid in T+3.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [3:0]           fun0,
  input  logic [3:0]           fun1,
  input  logic [IN_WIDTH-1:0]  a0,
  input  logic [IN_WIDTH-1:0]  b0,
  input  logic [IN_WIDTH-1:0]  a1,
  input  logic [IN_WIDTH-1:0]  b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [OUT_WIDTH-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [IN_WIDTH-1:0]  alu_a,
  output logic [IN_WIDTH-1:0]  alu_b,
  output logic [3:0]           alu_fun,
  output logic                 alu_en,
  input  logic [OUT_WIDTH-1:0] alu_out,
  input  logic                 alu_out_valid
);

  state_t                state_q, state_d;
  logic                  arb_en, any_gnt;
  logic                  id_q;
  logic [3:0]            fun_q;
  logic [IN_WIDTH-1:0]   a_q, b_q;
  logic                  rsp_id_q, rsp_err_q;
  logic [OUT_WIDTH-1:0]  rsp_data_q;

  // Grants only in IDLE; RST gating keeps gnt low while reset is held.
  assign arb_en  = (state_q == S_IDLE) & RST;
  assign any_gnt = gnt0 | gnt1;

  rr_arb2 u_arb (
    .clk  (clk),
    .RST  (RST),
    .en   (arb_en),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // State register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state: leave IDLE on a grant, then step unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_gnt) state_d = S_LOAD;
      S_LOAD:  state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the winner's request at grant. The operand registers drive the
  // ALU directly, so they hold still between operations.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      id_q  <= 1'b0;
      fun_q <= OP_NOP;
      a_q   <= '0;
      b_q   <= '0;
    end else if (any_gnt) begin
      id_q  <= gnt1;
      fun_q <= gnt1 ? fun1 : fun0;
      a_q   <= gnt1 ? a1 : a0;
      b_q   <= gnt1 ? b1 : b0;
    end
  end

  // Capture the ALU result at the end of EXEC; an invalid result reads as 0.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (state_q == S_EXEC) begin
      rsp_id_q   <= id_q;
      rsp_data_q <= alu_out_valid ? alu_out : '0;
      rsp_err_q  <= ~alu_out_valid;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_en    = (state_q == S_EXEC);
  assign alu_fun   = (state_q == S_EXEC) ? fun_q : OP_NOP;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        req0, req1;
  logic [3:0]  fun0, fun1;
  logic [7:0]  a0, b0, a1, b1;
  logic        gnt0, gnt1, rsp_valid, rsp_id, rsp_err, busy, alu_en;
  logic [15:0] rsp_data, alu_out;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic        alu_out_valid;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut (
    .clk(clk), .RST(RST),
    .req0(req0), .req1(req1), .fun0(fun0), .fun1(fun1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid)
  );

  logic [7:0] ra, rb;
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin ra <= '0; rb <= '0; end
    else      begin ra <= alu_a; rb <= alu_b; end
  end

  always_comb begin
    alu_out       = '0;
    alu_out_valid = alu_en;
    case (alu_fun)
      4'b0000: alu_out = {8'h00, ra} + {8'h00, rb};
      4'b0001: alu_out = {8'h00, ra} - {8'h00, rb};
      4'b0010: alu_out = {8'h00, ra} * {8'h00, rb};
      4'b0011: alu_out = (rb == 8'h00) ? 16'h0000 : {8'h00, ra / rb};
      4'b0101: alu_out = {8'h00, ra & rb};
      4'b1101: alu_out = {8'h00, ra} << rb;
      default: alu_out_valid = 1'b0;
    endcase
  end

  task automatic fail(input string tag);
    nerr++;
    $error("FAIL %s", tag);
  endtask

  task automatic do_op(input logic id, input logic [3:0] fun, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] d, input logic e);
    if (id) begin req1 = 1'b1; fun1 = fun; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; fun0 = fun; a0 = a; b0 = b; end
    #1;
    nchk++; if (gnt0 !== ~id) fail("op_gnt0");
    nchk++; if (gnt1 !== id) fail("op_gnt1");
    nchk++; if (busy !== 1'b0) fail("op_busy_idle");
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b; fun0 = 4'h0; fun1 = 4'h0;
    @(negedge clk);
    nchk++; if (busy !== 1'b1) fail("load_busy");
    nchk++; if (alu_a !== a) fail("load_alu_a");
    nchk++; if (alu_b !== b) fail("load_alu_b");
    nchk++; if (alu_en !== 1'b0) fail("load_alu_en");
    nchk++; if (alu_fun !== 4'hF) fail("load_alu_fun");
    @(negedge clk);
    nchk++; if (alu_en !== 1'b1) fail("exec_alu_en");
    nchk++; if (alu_fun !== fun) fail("exec_alu_fun");
    nchk++; if (rsp_valid !== 1'b0) fail("exec_rsp_valid");
    @(negedge clk);
    nchk++; if (rsp_valid !== 1'b1) fail("resp_valid");
    nchk++; if (rsp_id !== id) fail("resp_id");
    nchk++; if (rsp_data !== d) fail("resp_data");
    nchk++; if (rsp_err !== e) fail("resp_err");
    nchk++; if (alu_en !== 1'b0) fail("resp_alu_en");
    @(negedge clk);
    nchk++; if (rsp_valid !== 1'b0) fail("post_valid");
    nchk++; if (busy !== 1'b0) fail("post_busy");
    nchk++; if (rsp_data !== d) fail("post_data_hold");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic eg0, eg1, ev, eid;
    logic [15:0] ed;
    req0 = 1'b0; req1 = 1'b0; fun0 = 4'h0; fun1 = 4'h0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    repeat (2) @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    nchk++; if (gnt0 !== 1'b0) fail("rst_gnt0");
    nchk++; if (gnt1 !== 1'b0) fail("rst_gnt1");
    nchk++; if (busy !== 1'b0) fail("rst_busy");
    nchk++; if (rsp_valid !== 1'b0) fail("rst_valid");
    nchk++; if (rsp_data !== 16'h0000) fail("rst_data");
    nchk++; if (alu_fun !== 4'hF) fail("rst_alu_fun");
    nchk++; if (alu_en !== 1'b0) fail("rst_alu_en");
    nchk++; if (alu_a !== 8'h00) fail("rst_alu_a");
    req0 = 1'b0; req1 = 1'b0;
    RST = 1'b1;
    @(negedge clk);

    do_op(1'b0, 4'b0000, 8'd200, 8'd100, 16'd300, 1'b0);
    do_op(1'b1, 4'b0010, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    do_op(1'b1, 4'b0011, 8'd9, 8'd2, 16'd4, 1'b0);
    do_op(1'b0, 4'b1110, 8'd5, 8'd6, 16'h0000, 1'b1);
    do_op(1'b1, 4'b1101, 8'h81, 8'd1, 16'h0102, 1'b0);

    req0 = 1'b1; fun0 = 4'b0000; a0 = 8'd7; b0 = 8'd8;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nchk++; if (alu_en !== 1'b1) fail("abort_pre_en");
    RST = 1'b0;
    #1;
    nchk++; if (busy !== 1'b0) fail("abort_busy");
    nchk++; if (alu_en !== 1'b0) fail("abort_alu_en");
    nchk++; if (alu_fun !== 4'hF) fail("abort_alu_fun");
    nchk++; if (alu_a !== 8'h00) fail("abort_alu_a");
    nchk++; if (alu_b !== 8'h00) fail("abort_alu_b");
    nchk++; if (rsp_valid !== 1'b0) fail("abort_valid");
    nchk++; if (rsp_data !== 16'h0000) fail("abort_data");
    nchk++; if (rsp_id !== 1'b0) fail("abort_id");
    nchk++; if (rsp_err !== 1'b0) fail("abort_err");

    req0 = 1'b1; fun0 = 4'b0000; a0 = 8'd1;  b0 = 8'd2;
    req1 = 1'b1; fun1 = 4'b0001; a1 = 8'd10; b1 = 8'd3;
    @(negedge clk);
    RST = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      eg0 = ((k % 4) == 0) && (((k / 4) % 2) == 0);
      eg1 = ((k % 4) == 0) && (((k / 4) % 2) == 1);
      ev  = ((k % 4) == 3);
      eid = (((k / 4) % 2) == 1);
      ed  = eid ? 16'd7 : 16'd3;
      nchk++; if (gnt0 !== eg0) fail("rr_gnt0");
      nchk++; if (gnt1 !== eg1) fail("rr_gnt1");
      nchk++; if (rsp_valid !== ev) fail("rr_valid");
      if (ev) begin
        nchk++; if (rsp_id !== eid) fail("rr_id");
        nchk++; if (rsp_data !== ed) fail("rr_data");
      end
    end
    req0 = 1'b0; req1 = 1'b0;

    repeat (20) begin
      @(negedge clk);
      nchk++; if (alu_en !== 1'b0) fail("idle_alu_en");
      nchk++; if (busy !== 1'b0) fail("idle_busy");
      nchk++; if (alu_a !== 8'd10) fail("idle_alu_a");
      nchk++; if (alu_b !== 8'd3) fail("idle_alu_b");
      nchk++; if (rsp_valid !== 1'b0) fail("idle_valid");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: IN_WIDTH, default 8, operand width.
REQ-002 Parameter: OUT_WIDTH, default 16, result width.
REQ-003 Port: clk  input  1  clock; all state on rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-low.
REQ-005 Ports: req0/req1  input  1  operation request, requester 0/1.
REQ-006 Ports: fun0/fun1  input  4  ALU function code, requester 0/1.
REQ-007 Ports: a0,b0/a1,b1  input  IN_WIDTH  operands, requester 0/1.
REQ-008 Ports: gnt0/gnt1  output  1  one-cycle grant; operands accepted this cycle.
REQ-009 Port: rsp_valid  output  1  one-cycle response strobe.
REQ-010 Port: rsp_id  output  1  requester owning current response.
REQ-011 Port: rsp_data  output  OUT_WIDTH  result.
REQ-012 Port: rsp_err  output  1  illegal function code (ALU reported no valid output).
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Ports: alu_a, alu_b  output  IN_WIDTH  ALU operand drive.
REQ-015 Port: alu_fun  output  4  ALU function drive.
REQ-016 Port: alu_en  output  1  ALU enable.
REQ-017 Ports: alu_out  input  OUT_WIDTH; alu_out_valid  input  1  ALU result and valid.

Function
REQ-018 FSM states: IDLE, LOAD, EXEC, RESP; IDLE->LOAD on any grant, LOAD->EXEC, EXEC->RESP, RESP->IDLE unconditionally.
REQ-019 Grants issued only in IDLE; gntN is combinational and coincident with reqN in that cycle; at most one grant per cycle.
REQ-020 Arbitration: single requester wins; both requesting -> requester not granted last wins (round-robin); pointer updates only on grant.
REQ-021 On grant, fun/a/b of the winner and its id latched into internal registers; later input changes ignored until next grant.
REQ-022 LOAD: alu_a/alu_b driven from latched operands (ALU registers them at end of LOAD).
REQ-023 EXEC: alu_en=1, alu_fun=latched code; rsp_data/rsp_err captured at end of EXEC: data=alu_out, err=~alu_out_valid; err forces data=0.
REQ-024 RESP: rsp_valid=1 for exactly one cycle with rsp_id, rsp_data, rsp_err; data/id/err hold until next capture.
REQ-025 Latency: grant in cycle T -> rsp_valid in cycle T+3; max throughput one operation per 4 cycles.
REQ-026 alu_en=0 and alu_fun=4'b1111 outside EXEC; alu_a/alu_b hold last value outside LOAD/EXEC (no toggling when idle).
REQ-027 Request dropped before grant: no grant, no response; request held through RESP is eligible again in the following IDLE cycle.
REQ-028 Codes 4'b1110/4'b1111 are forwarded unchanged; error reported solely via alu_out_valid.

Reset
REQ-029 RST low: state=IDLE, gnt0/1=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, alu_a/alu_b=0, alu_fun=4'b1111, alu_en=0, RR pointer favors requester 0.
REQ-030 Reset mid-operation aborts it; no response for the aborted operation is produced after reset release.
REQ-031 First rising edge after RST deassertion may issue a grant.

Structure
REQ-032 Shared package alu_arb_pkg holds state encoding, ALU opcode constants (ADD=0000 ... SHL=1101, NOP=1111), and width defaults.
REQ-033 One sub-module: rr_arb2 (2-way round-robin, combinational grant, registered pointer); alu_arbiter instantiates it and the FSM/datapath.
REQ-034 ALU instance is external; alu_arbiter connects to it only through REQ-014..REQ-017 ports.

Verification
REQ-035 req0, fun0=0000, a0=8'd200, b0=8'd100 -> gnt0 at T, rsp_valid at T+3, rsp_id=0, rsp_data=16'd300, rsp_err=0.
REQ-036 req0 and req1 held together from reset -> grant order 0,1,0,1; each rsp_id matches grant; gnt spacing 4 cycles.
REQ-037 req1, fun1=0010, a1=8'hFF, b1=8'hFF -> rsp_data=16'hFE01; fun1=0011, a1=8'd9, b1=8'd2 -> rsp_data=16'd4.
REQ-038 req0, fun0=4'b1110 -> rsp_valid at T+3 with rsp_err=1, rsp_data=0; alu_en high only in EXEC.
REQ-039 RST asserted during EXEC -> all outputs at REQ-029 values immediately; no rsp_valid after release until new grant.
REQ-040 Idle 20 cycles after a response -> alu_en=0, alu_a/alu_b stable, busy=0 throughout.
